// File: rtl/cam_ov7670_emu_pkg.sv
// Shared constants for the OV7670 pixel-bus emulator:
// FSM states, pattern selects and RGB565 bar colours.
package cam_ov7670_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } cam_state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_INDEX = 2'd3;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_emu_pattern.sv
// Test-pattern generator: RGB565 colour for pixel (x, y),
// with incremental bar and index counters instead of divide/multiply.
module cam_emu_pattern
    import cam_ov7670_emu_pkg::*;
#(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned XW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    sel,
    input  logic [XW-1:0] x,
    input  logic [5:0]    y_hi,
    input  logic          px_step,
    input  logic          line_clr,
    input  logic          frame_clr,
    output logic [15:0]   p
);

    localparam logic [15:0]   XL     = 16'(CAM_SCREEN_X);
    localparam logic [XW-1:0] X_LAST = XW'(CAM_SCREEN_X - 1);

    logic [2:0]  bar_q, bar_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] rem_nx;

    // Invariant 8*x = bar*X + rem; one step per pixel suffices for X >= 8.
    always_comb begin
        bar_d  = bar_q;
        rem_d  = rem_q;
        idx_d  = idx_q;
        rem_nx = rem_q + 16'd8;
        if (line_clr) begin
            bar_d = 3'd0;
            rem_d = 16'd0;
        end else if (px_step && (x != X_LAST)) begin
            if (rem_nx >= XL) begin
                bar_d = bar_q + 3'd1;
                rem_d = rem_nx - XL;
            end else begin
                rem_d = rem_nx;
            end
        end
        if (frame_clr) begin
            idx_d = 16'd0;
        end else if (px_step) begin
            idx_d = idx_q + 16'd1;
        end
    end

    always_comb begin
        p = 16'd0;
        case (sel)
            PAT_BARS:  p = bar_colour(bar_q);
            PAT_GRAD:  p = {x[7:3], y_hi, ~x[7:3]};
            PAT_CHECK: p = (x[3] ^ y_hi[2]) ? 16'hFFFF : 16'h0000;
            default:   p = idx_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_q <= 3'd0;
            rem_q <= 16'd0;
            idx_q <= 16'd0;
        end else begin
            bar_q <= bar_d;
            rem_q <= rem_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/cam_ov7670_emu.sv
// OV7670-style pixel-bus transmitter: QQVGA vsync/href timing,
// RGB565 bytes (high first) from a selectable test pattern.
module cam_ov7670_emu
    import cam_ov7670_emu_pkg::*;
#(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned CAM_SCREEN_Y = 120,
    parameter int unsigned HBLANK       = 144,
    parameter int unsigned VSYNC_LINES  = 3,
    parameter int unsigned VBP_LINES    = 17,
    parameter int unsigned VFP_LINES    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       vsync,
    output logic       href,
    output logic [7:0] px_data,
    output logic       frame_done
);

    localparam int unsigned LINE_LEN  = 2 * CAM_SCREEN_X + HBLANK;
    localparam int unsigned MAX_LINES = max2(max2(VSYNC_LINES, VBP_LINES),
                                             max2(CAM_SCREEN_Y, VFP_LINES));
    // Minimum widths keep the pattern's x[7:3] / y[6:1] taps in range.
    localparam int unsigned HC_W = max2($clog2(LINE_LEN), 9);
    localparam int unsigned VC_W = max2($clog2(MAX_LINES), 7);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(LINE_LEN - 1);
    localparam logic [HC_W-1:0] HC_ACT  = HC_W'(2 * CAM_SCREEN_X);
    localparam logic [VC_W-1:0] VS_M1   = VC_W'(VSYNC_LINES - 1);
    localparam logic [VC_W-1:0] VBP_M1  = VC_W'(max2(VBP_LINES, 1) - 1);
    localparam logic [VC_W-1:0] ACT_M1  = VC_W'(CAM_SCREEN_Y - 1);
    localparam logic [VC_W-1:0] VFP_M1  = VC_W'(max2(VFP_LINES, 1) - 1);

    cam_state_e      state_q, state_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic [1:0]      sel_q, sel_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      px_q, px_d;
    logic            fd_q, fd_d;

    logic [VC_W-1:0] lines_m1;
    logic            line_end;
    logic            state_end;
    logic [15:0]     p;

    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        vc_d     = vc_q;
        sel_d    = sel_q;
        lines_m1 = '0;
        case (state_q)
            ST_VSYNC:  lines_m1 = VS_M1;
            ST_VBP:    lines_m1 = VBP_M1;
            ST_ACTIVE: lines_m1 = ACT_M1;
            ST_VFP:    lines_m1 = VFP_M1;
            default:   lines_m1 = '0;
        endcase
        line_end  = (hc_q == HC_LAST);
        state_end = line_end && (vc_q == lines_m1);
        if (line_end) begin
            hc_d = '0;
            vc_d = vc_q + VC_W'(1);
        end else begin
            hc_d = hc_q + HC_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                hc_d = '0;
                vc_d = '0;
                if (en) begin
                    state_d = ST_VSYNC;
                    sel_d   = pattern_sel;
                end
            end
            ST_VSYNC: begin
                if (state_end) begin
                    state_d = (VBP_LINES > 0) ? ST_VBP : ST_ACTIVE;
                end
            end
            ST_VBP: begin
                if (state_end) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (state_end) begin
                    if (VFP_LINES > 0) begin
                        state_d = ST_VFP;
                    end else if (en) begin
                        state_d = ST_VSYNC;
                        sel_d   = pattern_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_VFP: begin
                if (state_end) begin
                    if (en) begin
                        state_d = ST_VSYNC;
                        sel_d   = pattern_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            hc_d = '0;
            vc_d = '0;
        end
    end

    always_comb begin
        vsync_d = (state_q == ST_VSYNC);
        href_d  = (state_q == ST_ACTIVE) && (hc_q < HC_ACT);
        px_d    = 8'd0;
        if (href_d) begin
            px_d = hc_q[0] ? p[7:0] : p[15:8];
        end
        fd_d = (state_q == ST_ACTIVE) && (vc_q == ACT_M1) && (hc_q == HC_ACT);
    end

    cam_emu_pattern #(
        .CAM_SCREEN_X(CAM_SCREEN_X),
        .XW          (HC_W - 1)
    ) u_pattern (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel_q),
        .x        (hc_q[HC_W-1:1]),
        .y_hi     (vc_q[6:1]),
        .px_step  (href_d && hc_q[0]),
        .line_clr (!href_d),
        .frame_clr(state_q != ST_ACTIVE),
        .p        (p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            vc_q    <= '0;
            sel_q   <= 2'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            px_q    <= 8'd0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            sel_q   <= sel_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            px_q    <= px_d;
            fd_q    <= fd_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign px_data    = px_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_cam_ov7670_emu.sv
// Randomised scoreboard bench: frame-position reference model vs cam_ov7670_emu.
module tb_cam_ov7670_emu;

    localparam int TX   = 16;
    localparam int TY   = 12;
    localparam int THB  = 6;
    localparam int TVS  = 2;
    localparam int TVBP = 3;
    localparam int TVFP = 2;
    localparam int LL   = 2 * TX + THB;
    localparam int FRAME_LEN = (TVS + TVBP + TY + TVFP) * LL;

    localparam logic [15:0] BARS [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] px;
        logic       fd;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] pattern_sel;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;
    logic       frame_done;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    out_t exp_q [$];

    bit         in_frame = 1'b0;
    int         t_pos    = 0;
    logic [1:0] fsel     = 2'd0;

    cam_ov7670_emu #(
        .CAM_SCREEN_X(TX),
        .CAM_SCREEN_Y(TY),
        .HBLANK      (THB),
        .VSYNC_LINES (TVS),
        .VBP_LINES   (TVBP),
        .VFP_LINES   (TVFP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pattern_sel(pattern_sel),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [1:0] s, input int x, input int y);
        logic [15:0] xl;
        logic [15:0] yl;
        xl = 16'(x);
        yl = 16'(y);
        case (s)
            2'd0:    return BARS[(x * 8) / TX];
            2'd1:    return {xl[7:3], yl[6:1], ~xl[7:3]};
            2'd2:    return (xl[3] ^ yl[3]) ? 16'hFFFF : 16'h0000;
            default: return 16'((y * TX + x) % 65536);
        endcase
    endfunction

    function automatic out_t frame_out(input bit f, input int t, input logic [1:0] s);
        out_t o;
        int line;
        int hc;
        int al;
        logic [15:0] p;
        o = '0;
        if (f) begin
            line = t / LL;
            hc   = t % LL;
            al   = line - TVS - TVBP;
            o.vs = (line < TVS);
            if (al >= 0 && al < TY && hc < 2 * TX) begin
                p    = pat(s, hc / 2, al);
                o.hr = 1'b1;
                o.px = (hc % 2 == 1) ? p[7:0] : p[15:8];
            end
            o.fd = (al == TY - 1) && (hc == 2 * TX);
        end
        return o;
    endfunction

    // Reference: outputs after an edge reflect the frame position held before it.
    always @(posedge clk) begin
        out_t e;
        cyc = cyc + 1;
        if (!rst) begin
            e        = '0;
            in_frame = 1'b0;
        end else begin
            e = frame_out(in_frame, t_pos, fsel);
            if (!in_frame) begin
                if (en) begin
                    in_frame = 1'b1;
                    t_pos    = 0;
                    fsel     = pattern_sel;
                end
            end else if (t_pos == FRAME_LEN - 1) begin
                if (en) begin
                    t_pos = 0;
                    fsel  = pattern_sel;
                end else begin
                    in_frame = 1'b0;
                end
            end else begin
                t_pos = t_pos + 1;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        out_t e;
        out_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst) e = '0;
            g = '{vs: vsync, hr: href, px: px_data, fd: frame_done};
            n_chk = n_chk + 1;
            if (g !== e) begin
                n_bad = n_bad + 1;
                if (n_bad <= 20)
                    $display("FAIL bus cyc=%0d got vs=%0b hr=%0b px=%02h fd=%0b want vs=%0b hr=%0b px=%02h fd=%0b",
                             cyc, g.vs, g.hr, g.px, g.fd, e.vs, e.hr, e.px, e.fd);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        n_chk = n_chk + 1;
        if ({vsync, href, px_data, frame_done} !== 11'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got vs=%0b hr=%0b px=%02h fd=%0b want all zero",
                     name, vsync, href, px_data, frame_done);
        end
    endtask

    initial begin
        int r;
        int n;
        rst         = 1'b0;
        en          = 1'b1;
        pattern_sel = 2'd0;
        step(4);
        check_zero("reset_hold");
        rst = 1'b1;
        step(2 * FRAME_LEN);
        pattern_sel = 2'd3;
        step(FRAME_LEN / 2);
        pattern_sel = 2'd2;
        step(FRAME_LEN + FRAME_LEN / 2);
        for (int i = 0; i < 28; i++) begin
            r = $urandom_range(0, 9);
            n = $urandom_range(40, 1200);
            step(n / 2);
            pattern_sel = 2'($urandom_range(0, 3));
            step(n - n / 2);
            if (r < 2) begin
                en = 1'b0;
                step($urandom_range(100, FRAME_LEN + 200));
                en = 1'b1;
            end else if (r == 2) begin
                @(posedge clk);
                #2;
                rst = 1'b0;
                #1;
                check_zero("reset_async");
                step($urandom_range(1, 4));
                rst = 1'b1;
            end else if (r == 3) begin
                en = 1'b0;
                step($urandom_range(1, 5));
                en = 1'b1;
            end
        end
        en = 1'b0;
        step(2 * FRAME_LEN + 10);
        check_zero("idle_after_en_low");
        step(3);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
